instr_fetch_unit: RTL and testbench

//   IF stage of the 5-stage pipeline: owns the architectural PC register, issues fetches to

---
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory port of the fetch stage: valid/ready request channel
// plus an in-order, one-cycle-pulse response channel.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    // fetch unit side
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // memory side
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, keeps at most one fetch outstanding, and presents
// {pc, instruction} to IF/ID with a one-entry skid buffer behind a stalled
// output register. Redirects flush everything and restart fetch at the target.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   REQ   | present a fetch for pc (only while the skid buffer is empty)
//   WAIT  | request accepted, waiting for its response
//   DROP  | request in flight belongs to a flushed path; discard its response
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    instr_fetch_unit_if.master  imem,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    input  logic                stall,
    output logic                if_valid,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [INSTR_W-1:0]  if_instr
);

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetchState_t;

    fetchState_t        state;
    fetchState_t        nextState;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  reqAddr;
    logic [ADDR_W-1:0]  redirectPc;
    logic               skidValid;
    logic [ADDR_W-1:0]  skidPc;
    logic [INSTR_W-1:0] skidInstr;
    logic               running;
    logic               reqValid;
    logic               reqFire;
    logic               rspTake;

    // running holds requests off until the first edge after reset release
    assign redirectPc = redirect_target & ~ADDR_W'(3);
    assign reqValid   = running && (state == REQ) && !skidValid;
    assign reqFire    = reqValid && imem.imem_req_ready;
    assign rspTake    = (state == WAIT) && imem.imem_rsp_valid && !redirect_valid;

    assign imem.imem_req_valid = reqValid;
    assign imem.imem_req_addr  = pc;

    // state register and start-up flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= REQ;
            running <= 1'b0;
        end else begin
            state   <= nextState;
            running <= 1'b1;
        end
    end

    // next-state: a redirect turns any in-flight request into a stale one
    always_comb begin
        nextState = state;
        unique case (state)
            REQ: begin
                if (reqFire) begin
                    nextState = redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    nextState = REQ;
                end else if (redirect_valid) begin
                    nextState = DROP;
                end
            end
            DROP: begin
                if (imem.imem_rsp_valid) begin
                    nextState = REQ;
                end
            end
            default: nextState = REQ;
        endcase
    end

    // PC: redirect wins, otherwise advance when a good response lands
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            reqAddr <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirectPc;
            end else if (rspTake) begin
                pc <= pc + ADDR_W'(4);
            end
            if (reqFire) begin
                reqAddr <= pc;
            end
        end
    end

    // IF/ID output register and skid buffer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_instr  <= '0;
            skidValid <= 1'b0;
            skidPc    <= '0;
            skidInstr <= '0;
        end else if (redirect_valid) begin
            if_valid  <= 1'b0;
            skidValid <= 1'b0;
        end else if (if_valid && stall) begin
            if (rspTake) begin
                skidValid <= 1'b1;
                skidPc    <= reqAddr;
                skidInstr <= imem.imem_rsp_data;
            end
        end else if (skidValid) begin
            if_valid  <= 1'b1;
            if_pc     <= skidPc;
            if_instr  <= skidInstr;
            skidValid <= 1'b0;
        end else if (rspTake) begin
            if_valid <= 1'b1;
            if_pc    <= reqAddr;
            if_instr <= imem.imem_rsp_data;
        end else begin
            if_valid <= 1'b0;
        end
    end

    // a response with nothing outstanding means the memory broke the protocol
    assert property (@(posedge clk) disable iff (!reset_n)
        !((state == REQ) && imem.imem_rsp_valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model (expected fetch
// address, in-order delivery queue, held/bubbled IF/ID register).
module tb_instr_fetch_unit;
    localparam int          AW  = 64;
    localparam int          IW  = 32;
    localparam logic [63:0] RPC = 64'h0;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          redirect_valid;
    logic [AW-1:0] redirect_target;
    logic          stall;
    logic          if_valid;
    logic [AW-1:0] if_pc;
    logic [IW-1:0] if_instr;

    instr_fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem            (bus),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_instr        (if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model
    logic        mRun, mOut, mStale, mValid, mReqValid;
    logic [63:0] mNext, mPc;
    logic [31:0] mInstr;
    logic [95:0] mQ[$];

    // memory model
    logic        memBusy;
    int          memCnt;
    int          memLat;
    logic [63:0] memAddr;

    function automatic logic [31:0] memWord(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mRun = 1'b0; mOut = 1'b0; mStale = 1'b0; mValid = 1'b0;
        mPc = '0; mInstr = '0; mNext = RPC; mQ.delete();
        memBusy = 1'b0; memCnt = 0; memAddr = '0;
        redirect_valid = 1'b0; redirect_target = '0; stall = 1'b0;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_if_valid"}, if_valid, 0);
        check({tag, "_if_pc"}, if_pc, 0);
        check({tag, "_if_instr"}, if_instr, 0);
        check({tag, "_req_valid"}, bus.imem_req_valid, 0);
    endtask

    // one clock: drive inputs at negedge, advance model at the edge, check at next negedge
    task automatic tick(input logic rdr, input logic [63:0] tgt, input logic stl, input logic rdy);
        logic        rsp, acc, dutAcc;
        logic [63:0] dutAddr;
        rsp = memBusy && (memCnt == 1);
        acc = mRun && !mOut && (mQ.size() == 0) && rdy;
        redirect_valid     = rdr;
        redirect_target    = tgt;
        stall              = stl;
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? memWord(memAddr) : 32'($urandom());
        dutAcc  = bus.imem_req_valid && rdy;
        dutAddr = bus.imem_req_addr;
        @(posedge clk);
        if (rsp) memBusy = 1'b0;
        else if (memBusy) memCnt--;
        if (dutAcc) begin
            memBusy = 1'b1;
            memCnt  = (memLat != 0) ? memLat : int'($urandom_range(1, 4));
            memAddr = dutAddr;
        end
        if (rsp) begin
            if (!mStale && !rdr) begin
                mQ.push_back({mNext, memWord(mNext)});
                mNext = mNext + 64'd4;
            end
            mOut = 1'b0; mStale = 1'b0;
        end
        if (acc) begin mOut = 1'b1; mStale = 1'b0; end
        if (rdr) begin
            if (mOut) mStale = 1'b1;
            mNext = tgt & ~64'd3;
            mQ.delete();
            mValid = 1'b0;
        end else if (!(mValid && stl)) begin
            if (mQ.size() != 0) begin
                {mPc, mInstr} = mQ.pop_front();
                mValid = 1'b1;
            end else begin
                mValid = 1'b0;
            end
        end
        mRun = 1'b1;
        @(negedge clk);
        mReqValid = mRun && !mOut && (mQ.size() == 0);
        check("if_valid", if_valid, mValid);
        if (mValid) begin
            check("if_pc", if_pc, mPc);
            check("if_instr", if_instr, mInstr);
        end
        check("req_valid", bus.imem_req_valid, mReqValid);
        if (mReqValid) check("req_addr", bus.imem_req_addr, mNext);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [63:0] heldPc;
        logic [63:0] tgt;

        // reset
        reset_n = 1'b0;
        modelReset();
        memLat = 1;
        #12;
        checkZero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: back-to-back fetch, 1-cycle memory
        for (int i = 0; i < 14; i++) tick(1'b0, '0, 1'b0, 1'b1);

        // 2: stall across an arriving response fills the skid buffer
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t2_find", found, 1);
        heldPc = if_pc;
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, 1'b1);
        check("t2_held_pc", if_pc, heldPc);
        tick(1'b0, '0, 1'b0, 1'b1);
        check("t2_skid_valid", if_valid, 1);
        check("t2_skid_pc", if_pc, heldPc + 64'd4);
        for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b0, 1'b1);

        // 3: redirect while waiting on a slow response
        memLat = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mOut && !mStale && memCnt == 3) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t3_find", found, 1);
        tick(1'b1, 64'h1002, 1'b0, 1'b1);
        memLat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t3_find_valid", found, 1);
        check("t3_if_pc", if_pc, 64'h1000);

        // 4: redirect in the same cycle as the response
        memLat = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (memBusy && memCnt == 1 && !mStale) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t4_find", found, 1);
        tick(1'b1, 64'h2000, 1'b0, 1'b1);
        check("t4_flush", if_valid, 0);
        check("t4_req_addr", bus.imem_req_addr, 64'h2000);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t4_find_valid", found, 1);
        check("t4_if_pc", if_pc, 64'h2000);

        // 5: redirect + stall with valid output; fetch at top of memory wraps
        memLat = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t5_find", found, 1);
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b1);
        check("t5_flush", if_valid, 0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t5_find_valid", found, 1);
        check("t5_if_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_wrap_req", bus.imem_req_valid, 1);
        check("t5_wrap_addr", bus.imem_req_addr, 64'h0);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0, 1'b1);

        // 6: asynchronous reset in the middle of WAIT
        memLat = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mOut && !mStale) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t6_find", found, 1);
        tick(1'b0, '0, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkZero("t6_async");
        modelReset();
        memLat = 1;
        @(negedge clk);
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mValid) found = 1'b1; else tick(1'b0, '0, 1'b0, 1'b1);
        end
        check("t6_find_valid", found, 1);
        check("t6_if_pc", if_pc, RPC);

        // random traffic
        memLat = 0;
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 2))
                0:       tgt = {32'($urandom()), 32'($urandom())};
                1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: tgt = 64'($urandom_range(0, 255));
            endcase
            tick(($urandom % 16) == 0, tgt, ($urandom % 4) == 0, ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
